// File: rtl/adder_ppn.sv
// rtl/adder_ppn.sv - N-stage segmented carry pipelined adder with valid chain, stall and sat/wrap output
module adder_ppn #(
  parameter int C_IN1    = 12,
  parameter int C_IN2    = 12,
  parameter int C_OUT    = 13,
  parameter int C_STAGES = 2,
  parameter int C_SIGNED = 0,
  parameter int C_SAT    = 0
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_ce,
  input  logic             I_vld,
  input  logic [C_IN1-1:0] I_a,
  input  logic [C_IN2-1:0] I_b,
  output logic             O_vld,
  output logic [C_OUT-1:0] O_dout,
  output logic             O_ovf
);

  localparam int C_MAX = (C_IN1 > C_IN2) ? C_IN1 : C_IN2;
  localparam int C_W   = ((C_MAX + 1 + C_STAGES - 1) / C_STAGES) * C_STAGES;
  localparam int C_SEG = C_W / C_STAGES;

  logic             a_fill, b_fill;
  logic [C_W-1:0]   a_ext, b_ext;
  logic [C_W-1:0]   sum;

  // One guard bit is always present, so the C_W-bit sum cannot lose its carry-out.
  assign a_fill = (C_SIGNED != 0) & I_a[C_IN1-1];
  assign b_fill = (C_SIGNED != 0) & I_b[C_IN2-1];
  assign a_ext  = {{(C_W-C_IN1){a_fill}}, I_a};
  assign b_ext  = {{(C_W-C_IN2){b_fill}}, I_b};

  // acc carries finished sum segments below LO and untouched A segments above;
  // b carries only the B segments not yet consumed.
  for (genvar k = 0; k < C_STAGES; k++) begin : g_stage
    localparam int LO = k * C_SEG;
    localparam int BW = C_W - LO;

    logic [C_W-1:0]   acc_in, acc_d, acc_q;
    logic [BW-1:0]    b_in;
    logic             cin, vld_in, vld_q;
    logic [C_SEG-1:0] seg_sum;

    if (k == 0) begin : g_first
      assign acc_in = a_ext;
      assign b_in   = b_ext;
      assign cin    = 1'b0;
      assign vld_in = I_vld;
    end else begin : g_next
      assign acc_in = g_stage[k-1].acc_q;
      assign b_in   = g_stage[k-1].g_mid.b_q;
      assign cin    = g_stage[k-1].g_mid.cy_q;
      assign vld_in = g_stage[k-1].vld_q;
    end

    if (k < C_STAGES - 1) begin : g_mid
      logic [C_SEG:0]      seg_full;
      logic [BW-C_SEG-1:0] b_q;
      logic                cy_q;

      assign seg_full = {1'b0, acc_in[LO +: C_SEG]} + {1'b0, b_in[C_SEG-1:0]}
                      + (C_SEG+1)'(cin);
      assign seg_sum  = seg_full[C_SEG-1:0];

      always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
          b_q  <= '0;
          cy_q <= 1'b0;
        end else if (I_ce) begin
          b_q  <= b_in[BW-1:C_SEG];
          cy_q <= seg_full[C_SEG];
        end
      end
    end else begin : g_last
      // Top segment: its carry-out falls outside C_W and is not needed.
      assign seg_sum = acc_in[LO +: C_SEG] + b_in[C_SEG-1:0] + C_SEG'(cin);
    end

    always_comb begin
      acc_d              = acc_in;
      acc_d[LO +: C_SEG] = seg_sum;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        acc_q <= '0;
        vld_q <= 1'b0;
      end else if (I_ce) begin
        acc_q <= acc_d;
        vld_q <= vld_in;
      end
    end
  end

  assign sum   = g_stage[C_STAGES-1].acc_q;
  assign O_vld = g_stage[C_STAGES-1].vld_q;

  if (C_OUT >= C_W) begin : g_extend
    logic fill;
    assign fill   = (C_SIGNED != 0) & sum[C_W-1];
    assign O_dout = C_OUT'($signed({fill, sum}));
    assign O_ovf  = 1'b0;
  end else if (C_SIGNED != 0) begin : g_signed
    localparam logic [C_OUT-1:0] C_SMIN = C_OUT'(1) << (C_OUT - 1);
    localparam logic [C_OUT-1:0] C_SMAX = ~C_SMIN;
    logic [C_W-C_OUT:0] top;

    // In range only when every bit from C_OUT-1 upward is a copy of the sign.
    assign top    = sum[C_W-1:C_OUT-1];
    assign O_ovf  = ~((&top) | ~(|top));
    assign O_dout = ((C_SAT != 0) && O_ovf) ? (sum[C_W-1] ? C_SMIN : C_SMAX)
                                             : sum[C_OUT-1:0];
  end else begin : g_unsigned
    assign O_ovf  = |sum[C_W-1:C_OUT];
    assign O_dout = ((C_SAT != 0) && O_ovf) ? {C_OUT{1'b1}} : sum[C_OUT-1:0];
  end

endmodule

// File: tb/tb_adder_ppn.sv
// tb/tb_adder_ppn.sv - scoreboard bench for adder_ppn in default, signed-saturating and unsigned-wrap builds
module tb_adder_ppn;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ce_d, vld_d, vo_d, ovf_d;
  logic [11:0] a_d, b_d;
  logic [12:0] dout_d;

  logic        ce_s, vld_s, vo_s, ovf_s;
  logic [7:0]  a_s, b_s, dout_s;

  logic        ce_u, vld_u, vo_u, ovf_u;
  logic [7:0]  a_u, b_u, dout_u;

  adder_ppn u_def (
    .I_clk(clk), .I_rst_n(rst_n), .I_ce(ce_d), .I_vld(vld_d), .I_a(a_d), .I_b(b_d),
    .O_vld(vo_d), .O_dout(dout_d), .O_ovf(ovf_d)
  );

  adder_ppn #(.C_IN1(8), .C_IN2(8), .C_OUT(8), .C_STAGES(3), .C_SIGNED(1), .C_SAT(1)) u_ss (
    .I_clk(clk), .I_rst_n(rst_n), .I_ce(ce_s), .I_vld(vld_s), .I_a(a_s), .I_b(b_s),
    .O_vld(vo_s), .O_dout(dout_s), .O_ovf(ovf_s)
  );

  adder_ppn #(.C_IN1(8), .C_IN2(8), .C_OUT(8), .C_STAGES(2), .C_SIGNED(0), .C_SAT(0)) u_uw (
    .I_clk(clk), .I_rst_n(rst_n), .I_ce(ce_u), .I_vld(vld_u), .I_a(a_u), .I_b(b_u),
    .O_vld(vo_u), .O_dout(dout_u), .O_ovf(ovf_u)
  );

  typedef struct {
    int dout;
    int ovf;
    int ec;
  } exp_t;

  exp_t q_d[$], q_s[$], q_u[$];
  exp_t last_d;
  int total = 0, bad = 0;
  int ec_d = 0, ec_s = 0, ec_u = 0;
  int seen_d = 0, seen_s = 0, seen_u = 0;
  int n_d = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t m_def(input int a, input int b);
    exp_t e;
    int s;
    s = a + b;
    e.ovf  = (s > 8191) ? 1 : 0;
    e.dout = s % 8192;
    e.ec   = 0;
    return e;
  endfunction

  function automatic exp_t m_ss(input int a, input int b);
    exp_t e;
    int s, d;
    s = a + b;
    e.ovf = (s > 127 || s < -128) ? 1 : 0;
    d = (s > 127) ? 127 : ((s < -128) ? -128 : s);
    e.dout = d & 255;
    e.ec   = 0;
    return e;
  endfunction

  function automatic exp_t m_uw(input int a, input int b);
    exp_t e;
    int s;
    s = a + b;
    e.ovf  = (s > 255) ? 1 : 0;
    e.dout = s & 255;
    e.ec   = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    if (ce_d) ec_d <= ec_d + 1;
    ec_s <= ec_s + 1;
    ec_u <= ec_u + 1;
  end

  always @(negedge clk) begin
    if (ec_d != seen_d) begin
      seen_d = ec_d;
      if (vo_d) begin
        if (q_d.size() == 0) chk("def_unexp_vld", 1, 0);
        else begin
          exp_t e;
          e = q_d.pop_front();
          chk("def_dout", dout_d, e.dout);
          chk("def_ovf", ovf_d, e.ovf);
          chk("def_lat", ec_d - e.ec, 2);
          last_d = e;
          n_d++;
        end
      end
    end else if (vo_d) begin
      chk("def_hold_dout", dout_d, last_d.dout);
    end
  end

  always @(negedge clk) begin
    if (ec_s != seen_s) begin
      seen_s = ec_s;
      if (vo_s) begin
        if (q_s.size() == 0) chk("ss_unexp_vld", 1, 0);
        else begin
          exp_t e;
          e = q_s.pop_front();
          chk("ss_dout", dout_s, e.dout);
          chk("ss_ovf", ovf_s, e.ovf);
          chk("ss_lat", ec_s - e.ec, 3);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ec_u != seen_u) begin
      seen_u = ec_u;
      if (vo_u) begin
        if (q_u.size() == 0) chk("uw_unexp_vld", 1, 0);
        else begin
          exp_t e;
          e = q_u.pop_front();
          chk("uw_dout", dout_u, e.dout);
          chk("uw_ovf", ovf_u, e.ovf);
          chk("uw_lat", ec_u - e.ec, 2);
        end
      end
    end
  end

  task automatic drv_d(input logic v, input logic ce, input int a, input int b);
    @(posedge clk);
    #1;
    ce_d = ce; vld_d = v; a_d = a[11:0]; b_d = b[11:0];
    if (ce && v) begin
      exp_t e;
      e = m_def(a, b);
      e.ec = ec_d;
      q_d.push_back(e);
    end
  endtask

  task automatic drv_s(input logic v, input int a, input int b);
    @(posedge clk);
    #1;
    vld_s = v; a_s = a[7:0]; b_s = b[7:0];
    if (v) begin
      exp_t e;
      e = m_ss(a, b);
      e.ec = ec_s;
      q_s.push_back(e);
    end
  endtask

  task automatic drv_u(input logic v, input int a, input int b);
    @(posedge clk);
    #1;
    vld_u = v; a_u = a[7:0]; b_u = b[7:0];
    if (v) begin
      exp_t e;
      e = m_uw(a, b);
      e.ec = ec_u;
      q_u.push_back(e);
    end
  endtask

  initial begin
    ce_d = 1'b1; vld_d = 1'b0; a_d = '0; b_d = '0;
    ce_s = 1'b1; vld_s = 1'b0; a_s = '0; b_s = '0;
    ce_u = 1'b1; vld_u = 1'b0; a_u = '0; b_u = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_def_vld", vo_d, 0);
    chk("rst_def_dout", dout_d, 0);
    chk("rst_def_ovf", ovf_d, 0);
    chk("rst_ss_vld", vo_s, 0);
    chk("rst_uw_vld", vo_u, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drv_d(1, 1, 4095, 4095);
    repeat (5) drv_d(0, 1, 0, 0);
    chk("pulse_drained", q_d.size(), 0);

    n_d = 0;
    for (int i = 0; i < 16; i++) drv_d(1, 1, i, 2 * i);
    repeat (4) drv_d(0, 1, 0, 0);
    chk("stream_cnt", n_d, 16);

    n_d = 0;
    for (int i = 0; i < 16; i++) begin
      drv_d(1, 1, i, 2 * i);
      if (i == 5) repeat (3) drv_d(1, 0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    end
    repeat (4) drv_d(0, 1, 0, 0);
    chk("stall_cnt", n_d, 16);

    for (int i = 0; i < 40; i++)
      drv_d(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    repeat (4) drv_d(0, 1, 0, 0);
    chk("rand_def_drained", q_d.size(), 0);

    drv_s(1, 100, 100);
    drv_s(1, -100, -100);
    drv_s(1, -5, 3);
    drv_s(1, 127, -128);
    drv_s(1, -128, -128);
    for (int i = 0; i < 12; i++)
      drv_s(logic'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128);
    repeat (5) drv_s(0, 0, 0);
    chk("ss_drained", q_s.size(), 0);

    drv_u(1, 200, 100);
    drv_u(1, 100, 27);
    drv_u(1, 255, 255);
    drv_u(1, 128, 127);
    for (int i = 0; i < 12; i++)
      drv_u(logic'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    repeat (4) drv_u(0, 0, 0);
    chk("uw_drained", q_u.size(), 0);

    drv_d(1, 1, 11, 22);
    drv_d(1, 1, 33, 44);
    @(posedge clk);
    #1 vld_d = 1'b0;
    #1 chk("pre_rst_vld", vo_d, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", vo_d, 0);
    chk("mid_rst_dout", dout_d, 0);
    chk("mid_rst_ovf", ovf_d, 0);
    q_d.delete();
    @(posedge clk);
    #1 vld_d = 1'b1;
    @(posedge clk);
    #2 chk("rst_dominates_vld", vo_d, 0);
    vld_d = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2 chk("post_rst_vld", vo_d, 0);
    end

    n_d = 0;
    drv_d(1, 1, 1000, 2000);
    repeat (4) drv_d(0, 1, 0, 0);
    chk("fresh_after_rst", n_d, 1);
    chk("final_def_q", q_d.size(), 0);
    chk("final_ss_q", q_s.size(), 0);
    chk("final_uw_q", q_u.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
